hit_stager: RTL and testbench

HIT_STAGER -- requirements
Module: hit_stager

---
 rtl/hit_stager_pkg.sv | 21 ++
 rtl/hit_stager_if.sv | 28 ++
 rtl/hit_stager_bank.sv | 60 ++++++
 rtl/hit_stager.sv | 171 +++++++++++++++++
 tb/tb_hit_stager.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hit_stager_pkg.sv
// Shared fitter types: default sizes, the hit record and the
// read-side FSM state encoding used by the hit stager.
package hit_stager_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int NLAYER_DEF = 6;
  localparam int LAYER_W    = 3;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] x;
    logic [DATA_W_DEF-1:0] y;
    logic [DATA_W_DEF-1:0] z;
  } hit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/hit_stager_if.sv
// Hit beat handshake into the stager: valid/ready plus the
// layer, coordinates and end-of-track marker.
interface hit_stager_if #(
  parameter int DATA_W = hit_stager_pkg::DATA_W_DEF
);
  import hit_stager_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [LAYER_W-1:0] in_layer;
  logic [DATA_W-1:0]  in_x;
  logic [DATA_W-1:0]  in_y;
  logic [DATA_W-1:0]  in_z;
  logic               in_eot;

  modport master (
    output in_valid, in_layer,
    output in_x, in_y, in_z, in_eot,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_layer,
    input  in_x, in_y, in_z, in_eot,
    output in_ready
  );

endinterface

// File: rtl/hit_stager_bank.sv
// One track bank: NLAYER coordinate slots, per-slot present
// bits and a full flag marking a completed track.
module stager_bank
  import hit_stager_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NLAYER = NLAYER_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [LAYER_W-1:0] wr_layer,
  input  logic [DATA_W-1:0]  wr_x,
  input  logic [DATA_W-1:0]  wr_y,
  input  logic [DATA_W-1:0]  wr_z,
  input  logic               clr_present,
  input  logic               set_full,
  input  logic               clr_full,
  input  logic [LAYER_W-1:0] rd_layer,
  output logic [NLAYER-1:0]  present,
  output logic               full,
  output logic [DATA_W-1:0]  rd_x,
  output logic [DATA_W-1:0]  rd_y,
  output logic [DATA_W-1:0]  rd_z
);

  logic [DATA_W-1:0] x_mem [NLAYER];
  logic [DATA_W-1:0] y_mem [NLAYER];
  logic [DATA_W-1:0] z_mem [NLAYER];
  logic [NLAYER-1:0] wr_oh;

  assign wr_oh = NLAYER'(1) << wr_layer;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      x_mem[wr_layer] <= wr_x;
      y_mem[wr_layer] <= wr_y;
      z_mem[wr_layer] <= wr_z;
    end
  end

  // A clear on the same beat as a write wins: the track is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      present <= '0;
      full    <= 1'b0;
    end else begin
      if (clr_present)
        present <= '0;
      else if (wr_en)
        present <= present | wr_oh;
      full <= (full | set_full) & ~clr_full;
    end
  end

  assign rd_x = x_mem[rd_layer];
  assign rd_y = y_mem[rd_layer];
  assign rd_z = z_mem[rd_layer];

endmodule

// File: rtl/hit_stager.sv
// Double-banked hit stager: collects per-layer hits into a
// track and replays complete tracks in layer order.
module hit_stager
  import hit_stager_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NLAYER  = NLAYER_DEF,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  hit_stager_if.slave       hit,
  output logic              dv_out,
  output logic [DATA_W-1:0] data_out_x,
  output logic [DATA_W-1:0] data_out_y,
  output logic [DATA_W-1:0] data_out_z,
  output logic              sot_out,
  output logic              err_missing,
  output logic              err_dup,
  output logic              err_layer
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic wr_sel, wr_sel_n;
  logic rd_sel, rd_sel_n;
  logic [1:0] wr_en, clr_present;
  logic [1:0] set_full, clr_full;
  logic [1:0] full, full_n;
  logic [NLAYER-1:0] present [2];
  logic [DATA_W-1:0] bx [2];
  logic [DATA_W-1:0] by [2];
  logic [DATA_W-1:0] bz [2];

  logic accept, layer_ok, dup;
  logic store, all_present, byp;
  logic [NLAYER-1:0] lay_oh, wr_present;

  rd_state_e state, state_n;
  logic [LAYER_W-1:0] cnt, cnt_n, rd_layer;
  logic [GW-1:0] gap, gap_n;
  logic emit, last;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    stager_bank #(
      .DATA_W(DATA_W),
      .NLAYER(NLAYER)
    ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en[b]),
      .wr_layer    (hit.in_layer),
      .wr_x        (hit.in_x),
      .wr_y        (hit.in_y),
      .wr_z        (hit.in_z),
      .clr_present (clr_present[b]),
      .set_full    (set_full[b]),
      .clr_full    (clr_full[b]),
      .rd_layer    (rd_layer),
      .present     (present[b]),
      .full        (full[b]),
      .rd_x        (bx[b]),
      .rd_y        (by[b]),
      .rd_z        (bz[b])
    );
  end

  assign accept      = hit.in_valid & hit.in_ready;
  assign layer_ok    = 32'(hit.in_layer) < NLAYER;
  assign lay_oh      = layer_ok ? (NLAYER'(1) << hit.in_layer) : '0;
  assign wr_present  = present[wr_sel];
  assign dup         = |(lay_oh & wr_present);
  assign store       = accept & layer_ok & ~dup;
  assign all_present = &(wr_present | lay_oh);

  always_comb begin
    wr_en       = '0;
    clr_present = '0;
    set_full    = '0;
    wr_sel_n    = wr_sel;
    wr_en[wr_sel] = store;
    if (accept && hit.in_eot) begin
      if (all_present) begin
        set_full[wr_sel]     = 1'b1;
        clr_present[~wr_sel] = 1'b1;
        wr_sel_n             = ~wr_sel;
      end else begin
        clr_present[wr_sel] = 1'b1;
      end
    end
  end

  // IDLE starts on the eot edge itself so the first beat trails eot by one cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gap_n    = gap;
    rd_sel_n = rd_sel;
    clr_full = '0;
    emit     = 1'b0;
    rd_layer = cnt;
    unique case (state)
      IDLE: begin
        if (full[rd_sel] | set_full[rd_sel]) begin
          emit     = 1'b1;
          rd_layer = '0;
        end
      end
      SEND: emit = 1'b1;
      GAP: begin
        if (32'(gap) == GAP_CYC - 1)
          state_n = IDLE;
        else
          gap_n = gap + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    last = 32'(rd_layer) == NLAYER - 1;
    if (emit) begin
      if (last) begin
        clr_full[rd_sel] = 1'b1;
        rd_sel_n         = ~rd_sel;
        gap_n            = '0;
        state_n          = (GAP_CYC == 0) ? IDLE : GAP;
      end else begin
        state_n = SEND;
        cnt_n   = rd_layer + 1'b1;
      end
    end
  end

  assign full_n = (full | set_full) & ~clr_full;
  assign byp    = wr_en[rd_sel] && (hit.in_layer == rd_layer);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      gap          <= '0;
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      hit.in_ready <= 1'b0;
      dv_out       <= 1'b0;
      sot_out      <= 1'b0;
      data_out_x   <= '0;
      data_out_y   <= '0;
      data_out_z   <= '0;
      err_missing  <= 1'b0;
      err_dup      <= 1'b0;
      err_layer    <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      gap          <= gap_n;
      wr_sel       <= wr_sel_n;
      rd_sel       <= rd_sel_n;
      hit.in_ready <= ~full_n[wr_sel_n];
      dv_out       <= emit;
      sot_out      <= emit & (rd_layer == '0);
      if (emit) begin
        data_out_x <= byp ? hit.in_x : bx[rd_sel];
        data_out_y <= byp ? hit.in_y : by[rd_sel];
        data_out_z <= byp ? hit.in_z : bz[rd_sel];
      end
      err_missing <= accept & hit.in_eot & ~all_present;
      err_dup     <= accept & dup;
      err_layer   <= accept & ~layer_ok;
    end
  end

endmodule

// File: tb/tb_hit_stager.sv
// Directed bench for hit_stager: vector table of tracks plus
// back-to-back, stall and mid-burst reset sequences.
module tb_hit_stager;
  import hit_stager_pkg::*;

  localparam int DW = 16;
  localparam int NL = 6;

  logic clk = 1'b0;
  logic reset;
  logic dv_out, sot_out;
  logic err_missing, err_dup, err_layer;
  logic [DW-1:0] data_out_x, data_out_y, data_out_z;

  hit_stager_if #(.DATA_W(DW)) hif ();

  hit_stager #(
    .DATA_W(DW),
    .NLAYER(NL),
    .GAP_CYC(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hit         (hif),
    .dv_out      (dv_out),
    .data_out_x  (data_out_x),
    .data_out_y  (data_out_y),
    .data_out_z  (data_out_z),
    .sot_out     (sot_out),
    .err_missing (err_missing),
    .err_dup     (err_dup),
    .err_layer   (err_layer)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  hit_t qh[$];
  bit   qs[$];
  int   qc[$];
  hit_t h;
  int n_dup = 0, n_miss = 0, n_lay = 0, n_nrdy = 0;

  always @(negedge clk) begin
    if (dv_out) begin
      h.x = data_out_x;
      h.y = data_out_y;
      h.z = data_out_z;
      qh.push_back(h);
      qs.push_back(sot_out);
      qc.push_back(cyc);
    end
    if (err_dup) n_dup++;
    if (err_missing) n_miss++;
    if (err_layer) n_lay++;
    if (!hif.in_ready && !reset) n_nrdy++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input int lay, input int x, input bit eot);
    int n;
    n = 0;
    @(negedge clk);
    hif.in_valid = 1'b1;
    hif.in_layer = 3'(lay);
    hif.in_x     = 16'(x);
    hif.in_y     = 16'(x + 1000);
    hif.in_z     = 16'(x + 2000);
    hif.in_eot   = eot;
    while (!hif.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready", int'(hif.in_ready), 1);
    last_acc = cyc;
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    hif.in_valid = 1'b0;
    hif.in_eot   = 1'b0;
  endtask

  typedef struct {
    int n;
    int lay[8];
    int xv[8];
    int ex[6];
    int beats;
    int dup;
    int miss;
    int bad;
  } vec_t;

  vec_t v[6];
  int b0, d0, m0, l0, r0, nb;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    v[0] = '{6, '{0,1,2,3,4,5,0,0}, '{10,11,12,13,14,15,0,0},
             '{10,11,12,13,14,15}, 6, 0, 0, 0};
    v[1] = '{6, '{5,3,1,0,2,4,0,0}, '{105,103,101,100,102,104,0,0},
             '{100,101,102,103,104,105}, 6, 0, 0, 0};
    v[2] = '{7, '{0,1,2,2,3,4,5,0}, '{20,21,7,9,23,24,25,0},
             '{20,21,7,23,24,25}, 6, 1, 0, 0};
    v[3] = '{5, '{0,1,2,3,4,0,0,0}, '{30,31,32,33,34,0,0,0},
             '{0,0,0,0,0,0}, 0, 0, 1, 0};
    v[4] = '{7, '{0,1,6,2,3,4,5,0}, '{40,41,99,42,43,44,45,0},
             '{40,41,42,43,44,45}, 6, 0, 0, 1};
    v[5] = '{6, '{1,2,3,4,5,0,0,0}, '{51,52,53,54,55,50,0,0},
             '{50,51,52,53,54,55}, 6, 0, 0, 0};

    hif.in_valid = 1'b0;
    hif.in_layer = '0;
    hif.in_x = '0;
    hif.in_y = '0;
    hif.in_z = '0;
    hif.in_eot = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst dv_out", int'(dv_out), 0);
    chk("rst in_ready", int'(hif.in_ready), 0);
    chk("rst data_x", int'(data_out_x), 0);
    chk("rst errs", int'({err_missing, err_dup, err_layer, sot_out}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", int'(hif.in_ready), 1);

    for (int k = 0; k < 6; k++) begin
      b0 = qh.size();
      d0 = n_dup;
      m0 = n_miss;
      l0 = n_lay;
      for (int i = 0; i < v[k].n; i++)
        beat(v[k].lay[i], v[k].xv[i], i == v[k].n - 1);
      idle_in();
      repeat (14) @(negedge clk);
      chk($sformatf("v%0d beats", k), qh.size() - b0, v[k].beats);
      for (int i = 0; i < v[k].beats && b0 + i < qh.size(); i++) begin
        chk($sformatf("v%0d x[%0d]", k, i), int'(qh[b0+i].x), v[k].ex[i]);
        chk($sformatf("v%0d y[%0d]", k, i), int'(qh[b0+i].y), v[k].ex[i] + 1000);
        chk($sformatf("v%0d z[%0d]", k, i), int'(qh[b0+i].z), v[k].ex[i] + 2000);
        chk($sformatf("v%0d sot[%0d]", k, i), int'(qs[b0+i]), int'(i == 0));
      end
      if (v[k].beats > 0 && qh.size() > b0) begin
        chk($sformatf("v%0d latency", k), qc[b0] - last_acc, 1);
        chk($sformatf("v%0d hold", k), int'(data_out_x), v[k].ex[5]);
      end
      chk($sformatf("v%0d err_dup", k), n_dup - d0, v[k].dup);
      chk($sformatf("v%0d err_missing", k), n_miss - m0, v[k].miss);
      chk($sformatf("v%0d err_layer", k), n_lay - l0, v[k].bad);
    end

    b0 = qh.size();
    r0 = n_nrdy;
    for (int t = 0; t < 3; t++)
      for (int l = 0; l < 6; l++)
        beat(l, 200 + 10 * t + l, l == 5);
    idle_in();
    repeat (30) @(negedge clk);
    chk("b2b beats", qh.size() - b0, 18);
    if (qh.size() >= b0 + 18) begin
      for (int i = 0; i < 18; i++)
        chk($sformatf("b2b x[%0d]", i), int'(qh[b0+i].x),
            200 + 10 * (i / 6) + (i % 6));
      chk("b2b burst len", qc[b0+5] - qc[b0], 5);
      chk("b2b gap1", qc[b0+6] - qc[b0+5] - 1, 4);
      chk("b2b gap2", qc[b0+12] - qc[b0+11] - 1, 4);
    end
    chk("b2b stall seen", int'((n_nrdy - r0) > 0), 1);

    nb = 0;
    for (int l = 0; l < 6; l++)
      beat(l, 60 + l, l == 5);
    for (int i = 0; i < 20 && nb < 3; i++) begin
      @(negedge clk);
      hif.in_valid = 1'b0;
      hif.in_eot = 1'b0;
      if (dv_out) nb++;
    end
    chk("abort reached beat 3", nb, 3);
    reset = 1'b1;
    #1;
    chk("abort dv_out", int'(dv_out), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    b0 = qh.size();
    repeat (8) @(negedge clk);
    chk("abort no dv", qh.size() - b0, 0);

    b0 = qh.size();
    for (int l = 0; l < 6; l++)
      beat(l, 80 + l, l == 5);
    idle_in();
    repeat (14) @(negedge clk);
    chk("recover beats", qh.size() - b0, 6);
    for (int i = 0; i < 6 && b0 + i < qh.size(); i++) begin
      chk($sformatf("recover x[%0d]", i), int'(qh[b0+i].x), 80 + i);
      chk($sformatf("recover sot[%0d]", i), int'(qs[b0+i]), int'(i == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
